// File: rtl/native_bus_dma.sv
// native_bus_dma
// Bus initiator on the PicoRV32 native memory interface. Copies a block of
// 32-bit words (read one word, write it, repeat) or fills a block with a
// constant word, without CPU involvement. Requests decode exactly like CPU
// data accesses; arbitration against the CPU happens outside this block.
//
// Ports
//   clk_i, reset_i      system clock, synchronous active-high reset
//   start_i             one-cycle pulse, captures the configuration below
//   mode_i              0 = copy, 1 = fill
//   src_addr_i          copy source byte address (bits [1:0] ignored)
//   dst_addr_i          destination byte address (bits [1:0] ignored)
//   len_words_i         number of words to transfer
//   fill_value_i        word written in fill mode
//   busy_o              job in progress
//   done_o / error_o    one-cycle completion / timeout-abort pulses
//   words_done_o        completed writes in the current or last job
//   mem_*               PicoRV32 native memory interface (initiator side)
//   checksum_o          running sum of written words (optional feature)
//
// Optional feature: define DMA_CHECKSUM_EN to accumulate a modulo-2^32 sum
// of every written word on checksum_o. Without it checksum_o is tied to 0.
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start
// S_RD    | read request on the bus (copy only)
// S_GAP_W | one idle bus cycle, then write
// S_WR    | write request on the bus
// S_GAP_R | one idle bus cycle, then read (copy only)
// S_FIN   | job complete, done pulses in the following cycle
// S_ABORT | timeout, error pulses in the following cycle

module native_bus_dma #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_words_i,
    input  logic [31:0]       fill_value_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [LEN_W-1:0]  words_done_o,
    output logic              mem_valid_o,
    output logic              mem_instr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       checksum_o
);

    // Wait timer is a down-counter: loaded with TIMEOUT_CYCLES-1 outside the
    // request states, terminal count 0 on a non-ready cycle means timeout.
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_GAP_W,
        S_WR,
        S_GAP_R,
        S_FIN,
        S_ABORT
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  words_done_q, words_done_d;
    logic [31:0]       fill_q, fill_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [TO_W-1:0]   tmr_q, tmr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       wr_word;
`ifdef DMA_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    assign wr_word = mode_q ? fill_q : rdata_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        words_done_d = words_done_q;
        fill_d       = fill_q;
        rdata_d      = rdata_q;
        tmr_d        = TO_LOAD;
        done_d       = 1'b0;
        error_d      = 1'b0;
`ifdef DMA_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        mem_valid_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_wstrb_o  = 4'b0000;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_words_i == '0) begin
                        // Empty job: report completion without touching the bus.
                        done_d = 1'b1;
                    end else begin
                        mode_d       = mode_i;
                        src_d        = src_addr_i;
                        dst_d        = dst_addr_i;
                        rem_d        = len_words_i;
                        fill_d       = fill_value_i;
                        words_done_d = '0;
`ifdef DMA_CHECKSUM_EN
                        csum_d       = '0;
`endif
                        state_d      = mode_i ? S_WR : S_RD;
                    end
                end
            end

            S_RD: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = {src_q[ADDR_W-1:2], 2'b00};
                tmr_d       = tmr_q;
                // A handshake on the terminal-count cycle still completes.
                if (mem_ready_i) begin
                    rdata_d = mem_rdata_i;
                    src_d   = src_q + ADDR_W'(4);
                    state_d = S_GAP_W;
                end else if (tmr_q == '0) begin
                    state_d = S_ABORT;
                end else begin
                    tmr_d = tmr_q - TO_W'(1);
                end
            end

            S_WR: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = {dst_q[ADDR_W-1:2], 2'b00};
                mem_wdata_o = wr_word;
                mem_wstrb_o = 4'b1111;
                tmr_d       = tmr_q;
                if (mem_ready_i) begin
                    dst_d        = dst_q + ADDR_W'(4);
                    words_done_d = words_done_q + LEN_W'(1);
                    rem_d        = rem_q - LEN_W'(1);
`ifdef DMA_CHECKSUM_EN
                    csum_d       = csum_q + wr_word;
`endif
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = mode_q ? S_GAP_W : S_GAP_R;
                    end
                end else if (tmr_q == '0) begin
                    state_d = S_ABORT;
                end else begin
                    tmr_d = tmr_q - TO_W'(1);
                end
            end

            S_GAP_W: state_d = S_WR;
            S_GAP_R: state_d = S_RD;

            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            S_ABORT: begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            words_done_q <= '0;
            fill_q       <= '0;
            rdata_q      <= '0;
            tmr_q        <= TO_LOAD;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef DMA_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            words_done_q <= words_done_d;
            fill_q       <= fill_d;
            rdata_q      <= rdata_d;
            tmr_q        <= tmr_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef DMA_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // FIN/ABORT still count as busy; busy drops in the cycle done/error pulses.
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign words_done_o = words_done_q;
    assign mem_instr_o  = 1'b0;

`ifdef DMA_CHECKSUM_EN
    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: doc/native_bus_dma.md
Name: native_bus_dma

Overview:
- Bus initiator on the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Performs word block copies (read then write) or word fills without CPU involvement. Typical uses: clearing the game-state RAM region, or copying sprite/obstacle tables between scalar RAM and SDRAM.
- Sits beside the CPU in front of the SoC address decoder. Its requests are arbitrated externally and decode exactly like CPU data accesses.

Parameters:
- ADDR_W, 32, width of the address bus and address registers.
- LEN_W, 16, width of the word-count field.
- TIMEOUT_CYCLES, 1024, maximum cycles mem_valid may wait for mem_ready before the transfer aborts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; captures the configuration inputs.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  ADDR_W  copy source byte address; bits [1:0] ignored.
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored.
- len_words  in  LEN_W  number of 32-bit words to transfer.
- fill_value  in  32  word written in fill mode.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on timeout abort.
- words_done  out  LEN_W  count of completed writes in the current or last job.
- mem_valid  out  1  request valid.
- mem_instr  out  1  constant 0.
- mem_addr  out  32  word-aligned request address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 for writes, 4'b0000 for reads.
- mem_ready  in  1  responder handshake.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1 on a read.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0 and state is IDLE.
  - Asserting reset mid-transfer drops mem_valid in the next cycle. The aborted job does not pulse done or error.
- States:
  - IDLE:
    - start with len_words=0: done pulses next cycle, no bus activity, busy stays 0.
    - start otherwise: latch cfg, words_done=0, checksum=0, busy=1; go to RD (copy) or WR (fill).
  - RD:
    - Assert mem_valid, mem_addr={src[31:2],2'b00}, mem_wstrb=0.
    - On mem_valid&&mem_ready: capture mem_rdata, src+=4, go to GAP_W.
  - WR:
    - Assert mem_valid, mem_addr={dst[31:2],2'b00}, mem_wdata = captured word (copy) or fill_value (fill), mem_wstrb=4'b1111.
    - On handshake: dst+=4, words_done+=1, remaining-=1. If remaining was 1, go to FIN; else go to GAP_R (copy) or GAP_W (fill).
  - GAP_R / GAP_W: mem_valid=0 for exactly one cycle, then go to RD / WR. This lets the SoC ready registers (ram_valid etc.) clear between requests.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
  - ABORT: error=1 for one cycle, busy=0, go to IDLE. words_done holds the partial count.
- Handshake rules:
  - While mem_valid=1, mem_addr, mem_wdata and mem_wstrb are held stable until the handshake cycle.
  - mem_valid falls in the cycle after the handshake.
  - mem_ready seen while mem_valid=0 is ignored.
- Timeout:
  - A counter clears on entry to RD/WR and increments each cycle mem_valid=1 without mem_ready.
  - Reaching TIMEOUT_CYCLES without a handshake drops mem_valid and enters ABORT.
  - A handshake in the same cycle the count hits the limit wins: the transfer continues.
- Arithmetic:
  - Addresses increment modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - remaining is LEN_W wide. The maximum len 2^LEN_W-1 is legal.
- start while busy=1 is ignored; configuration is unchanged.
- Latency: copy of N words = 4N+1 cycles from start to done with zero-wait responders; fill = 2N+1.

Optional Feature:
- Macro DMA_CHECKSUM_EN.
- Defined: checksum accumulates the modulo-2^32 sum of every word written (on each WR handshake). It clears on accepted start and holds after done/error.
- Undefined: checksum is constant 0 and no adder is synthesized.

Test Plan:
- Fill, zero-wait responder: mode=1, dst=0x100, len=4, fill=0xDEADBEEF -> four writes to 0x100, 0x104, 0x108, 0x10C with wstrb=F; done at cycle 9; words_done=4; checksum=0x7AB6FBBC with the macro defined.
- Copy, responder ready after 2 waits: src 0x200 holding {1,2,3}, dst 0x300, len=3 -> reads then writes alternate; 0x300..0x308 = 1,2,3; address stable during waits; done pulses once.
- len_words=0 -> done 1 cycle after start, mem_valid never asserted, busy stays 0.
- Responder never ready, TIMEOUT_CYCLES=8, fill len=2 -> mem_valid high for 8 cycles, then error pulse, busy=0, words_done=0.
- dst=0xFFFFFFFC, fill len=2 -> write addresses 0xFFFFFFFC then 0x00000000.
- Second start mid-copy ignored; reset asserted mid-WR -> mem_valid=0 next cycle, no done/error, all outputs 0.
